// File: rtl/modified_fredkin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : modified_fredkin                                                |
// | Brief    : Registered bit-parallel array of modified Fredkin gate cells.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

// One gate cell. With the ancilla c tied low, r reduces to a AND b.
module modified_fredkin_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic q,
  output logic r
);
  assign p = a;
  assign q = a ^ b;
  assign r = a ? b : c;
endmodule

module modified_fredkin #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);
  localparam logic c_ancilla = 1'b0;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  // Lanes are fully independent; no carry or cross-lane terms.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    modified_fredkin_cell u_cell (
      .a (A[i]),
      .b (B[i]),
      .c (c_ancilla),
      .p (w_p[i]),
      .q (w_q[i]),
      .r (w_r[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
      r_q <= '0;
      r_r <= '0;
    end else begin
      r_p <= w_p;
      r_q <= w_q;
      r_r <= w_r;
    end
  end

  assign P = r_p;
  assign Q = r_q;
  assign R = r_r;
endmodule
`default_nettype wire

// File: tb/tb_modified_fredkin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_modified_fredkin                                             |
// | Brief    : Directed and random self-checking bench for modified_fredkin.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_modified_fredkin;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A   = '0;
  logic [31:0] B   = '0;
  logic [31:0] P;
  logic [31:0] Q;
  logic [31:0] R;
  int          n_checks = 0;
  int          n_fail   = 0;

  modified_fredkin #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .P   (P),
    .Q   (Q),
    .R   (R)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({P, Q, R} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_initial: got P=%h Q=%h R=%h expected all 0", P, Q, R);
    end
    @(negedge clk);
    rst = 1'b0;
    A = 32'hFFFFFFFF;
    B = 32'h0F0F0F0F;
    @(posedge clk); #1;
    n_checks++;
    if ({P, Q, R} !== {32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0F0F0F0F}) begin
      n_fail++;
      $display("FAIL reset_preload: got P=%h Q=%h R=%h expected FFFFFFFF F0F0F0F0 0F0F0F0F", P, Q, R);
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({P, Q, R} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_async: got P=%h Q=%h R=%h expected all 0", P, Q, R);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({P, Q, R} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got P=%h Q=%h R=%h expected all 0", P, Q, R);
    end
    @(negedge clk);
    rst = 1'b0;
    A = 32'hA5A5A5A5;
    B = 32'h5A5A5A5A;
    @(posedge clk); #1;
    n_checks++;
    if ({P, Q, R} !== {32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000}) begin
      n_fail++;
      $display("FAIL reset_release: got P=%h Q=%h R=%h expected A5A5A5A5 FFFFFFFF 00000000", P, Q, R);
    end
  endtask

  // Applies each vector, then checks outputs one edge later.
  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] ep [7];
    logic [31:0] eq [7];
    logic [31:0] er [7];
    va = '{32'hFFFFFFFF, 32'h00000000, 32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vb = '{32'h00000000, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h87654321, 32'hFFFFFFFF, 32'h00000000, 32'hC3C3C3C3};
    ep = '{32'hFFFFFFFF, 32'h00000000, 32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    eq = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h95511559, 32'h00000000, 32'h00000000, 32'hC3C3C3C3};
    er = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h02244220, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      A = va[i];
      B = vb[i];
      @(posedge clk); #1;
      n_checks++;
      if ({P, Q, R} !== {ep[i], eq[i], er[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d: got P=%h Q=%h R=%h expected %h %h %h",
                 i, P, Q, R, ep[i], eq[i], er[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] eq [5];
    logic [31:0] er [5];
    va = '{32'h00000001, 32'hDEADBEEF, 32'hFFFF0000, 32'h80000000, 32'h3C3C3C3C};
    vb = '{32'h00000003, 32'hFFFFFFFF, 32'h00FFFF00, 32'h80000001, 32'h0FF00FF0};
    eq = '{32'h00000002, 32'h21524110, 32'hFF00FF00, 32'h00000001, 32'h33CC33CC};
    er = '{32'h00000001, 32'hDEADBEEF, 32'h00FF0000, 32'h80000000, 32'h0C300C30};
    @(negedge clk);
    A = va[0];
    B = vb[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({P, Q, R} !== {va[i], eq[i], er[i]}) begin
        n_fail++;
        $display("FAIL stream_%0d: got P=%h Q=%h R=%h expected %h %h %h",
                 i, P, Q, R, va[i], eq[i], er[i]);
      end
      // New inputs mid-cycle must not disturb registered outputs.
      A = ~va[i];
      B = (i < 4) ? vb[i+1] : 32'h0;
      #3;
      n_checks++;
      if ({P, Q, R} !== {va[i], eq[i], er[i]}) begin
        n_fail++;
        $display("FAIL stream_stable_%0d: got P=%h Q=%h R=%h expected %h %h %h",
                 i, P, Q, R, va[i], eq[i], er[i]);
      end
      if (i < 4) A = va[i+1];
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      A = a;
      B = b;
      @(posedge clk); #1;
      n_checks++;
      if ({P, Q, R} !== {a, a ^ b, a & b}) begin
        n_fail++;
        $display("FAIL random_%0d: A=%h B=%h got P=%h Q=%h R=%h", i, a, b, P, Q, R);
      end
      n_checks++;
      if (P !== a || (Q ^ P) !== b || (Q & R) !== 32'h0) begin
        n_fail++;
        $display("FAIL reversible_%0d: A=%h B=%h got P=%h Q^P=%h Q&R=%h",
                 i, a, b, P, Q ^ P, Q & R);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/modified_fredkin.md
Name: modified_fredkin

Overview:
- Registered, bit-parallel array of modified Fredkin reversible gates. It is the primitive logic stage of the reversible-logic ALU.
- Each bit lane i applies one gate cell to A[i] and B[i], with the gate's third (ancilla) input tied to constant 0.
- Outputs are registered on the rising clock edge and feed the downstream ALU result mux.

Parameters:
- WIDTH, 32, number of independent bit lanes (gate cells); must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all output registers.
- A  input  WIDTH  gate control/data input, one bit per lane.
- B  input  WIDTH  gate data input, one bit per lane.
- P  output  WIDTH  registered pass-through output.
- Q  output  WIDTH  registered propagate output.
- R  output  WIDTH  registered generate output.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Per-lane gate function, evaluated combinationally, bitwise, with no carry or interaction between lanes:
  - p_next[i] = A[i]
  - q_next[i] = A[i] XOR B[i]
  - r_next[i] = A[i] AND B[i]
- Registering:
  - On each rising clk edge with rst low: P<=p_next, Q<=q_next, R<=r_next.
  - Latency is exactly 1 cycle from the sampled A/B to the outputs. No enable and no handshake; a new result every cycle.
- Reset:
  - rst high forces P=Q=R=0 immediately, without waiting for a clock edge, and holds them at 0 while rst is high.
  - The first rising edge after rst deasserts loads the gate results of the A/B present at that edge.
  - Reset asserted mid-stream discards the in-flight result.
- Outputs are driven only from flops; there is no combinational path from A/B to P/Q/R.
- Boundary conditions:
  - A=0: Q=B, R=0.
  - A=all-ones: Q=~B, R=B.
  - Q and R are never both 1 in the same lane.
- No overflow or width growth: every output is exactly WIDTH bits.
- X/Z on any input bit propagates only to the affected lane.
- Reversibility check (verification invariant, one cycle later): A = P and B = Q XOR P.
- Implementation uses a generate loop instantiating one gate-cell submodule per lane, plus the output register block.

Test Plan:
- Reset: assert rst between clock edges with prior outputs nonzero -> P=Q=R=32'h00000000 immediately and held while rst is high. Release rst with A=32'hA5A5A5A5, B=32'h5A5A5A5A -> after the next edge P=A5A5A5A5, Q=FFFFFFFF, R=00000000.
- Complementary operands: A=FFFFFFFF, B=00000000 -> P=FFFFFFFF, Q=FFFFFFFF, R=00000000. A=00000000, B=FFFFFFFF -> P=00000000, Q=FFFFFFFF, R=00000000. A=0F0F0F0F, B=F0F0F0F0 -> P=0F0F0F0F, Q=FFFFFFFF, R=00000000.
- Mixed pattern: A=12345678, B=87654321 -> P=12345678, Q=95511559, R=02244220 one cycle later.
- Overlapping ones: A=FFFFFFFF, B=FFFFFFFF -> P=FFFFFFFF, Q=00000000, R=FFFFFFFF. A=B=00000000 -> all outputs 0.
- Latency and streaming: change A/B every cycle for 5 cycles -> each output set matches the vector applied exactly one edge earlier. Outputs do not change between edges.
- Random regression: 1000 random A/B vectors -> Q==A^B, R==A&B, P==A, and the reversibility invariant holds for every vector.
